sysreg_star_ctrl: RTL
=====================

Name: sysreg_star_ctrl

Overview:
- Registered, parametrised system-register star interconnect between the core sysreg request port and NR_NODES register nodes.
- Single outstanding transaction. Read and write share one request channel, answered on one response channel with an error code.
- Adds features the previous-generation star does not have:
  - ready/valid handshakes on both channels
  - per-node acknowledge
  - unmapped-group detection
  - timeout
  - registered node outputs

Parameters:
- REG_WIDTH, 64: data width.
- NR_NODES, 11: number of nodes; group g maps to node g for g < NR_NODES.
- GROUP_W, 5: group field width; requires 2**GROUP_W >= NR_NODES.
- REGNUM_W, 3: register number width within a node.
- TIMEOUT, 15: cycles to wait for node ack after enable; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_write  in  1  1=write, 0=read
- req_group  in  GROUP_W  target group
- req_regnum  in  REGNUM_W  register number
- req_plevel  in  2  privilege level
- req_wdata  in  REG_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_code  out  2  0=OK, 1=NODE_ERR, 2=UNMAPPED, 3=TIMEOUT
- resp_rdata  out  REG_WIDTH  read data
- node_en  out  NR_NODES  one-hot access strobe
- node_write  out  1  broadcast: write flag
- node_regnum  out  REGNUM_W  broadcast
- node_plevel  out  2  broadcast
- node_wdata  out  REG_WIDTH  broadcast
- node_ack  in  NR_NODES  per-node completion
- node_err  in  NR_NODES  per-node error, qualified by that node's ack
- node_rdata  in  NR_NODES x REG_WIDTH  per-node read data, unpacked array

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_code=0; resp_rdata=0; node_en=0; node_write=0; node_regnum=0; node_plevel=0; node_wdata=0; timeout counter=0.
- State IDLE:
  - req_ready=1.
  - On req_valid, latch the request into the captured request registers.
  - If req_group < NR_NODES: go to ISSUE and capture the node index.
  - Otherwise: go to RESP with resp_code=2 and rdata=0; no node_en is ever driven.
- State ISSUE (1 cycle):
  - node_en[idx]=1; broadcast fields driven from the captured request.
  - Counter cleared. Go to WAIT.
- State WAIT:
  - node_en=0; broadcast fields hold their values.
  - Only node_ack[idx] is observed; acks on other bits are ignored.
  - An ack is also recognised in the ISSUE cycle, supporting combinational nodes.
  - On ack: resp_code = node_err[idx] ? 1 : 0.
  - resp_rdata = node_rdata[idx] for an OK read; 0 for writes and errors. Then go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with no ack: resp_code=3, rdata=0, go to RESP.
  - Ack in the same cycle the timeout expires: the ack wins.
- State RESP:
  - resp_valid=1; code and data are held stable until resp_ready.
  - On resp_valid & resp_ready: return to IDLE; resp_valid deasserts the next cycle.
  - req_ready=0 in every state except IDLE.
- Minimum latency: request accepted at cycle N, node_en at N+1, ack at N+1, resp_valid at N+2.
- Timeout path: resp_valid at N+2+TIMEOUT.
- Late ack from a timed-out node arriving in RESP or IDLE: ignored.
- rst asserted mid-transaction: all state returns to reset values on the next edge. No response is produced for the aborted transaction.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

Optional Feature:
- Macro SYSREG_STAR_ERR_STATUS_EN.
- Defined: adds outputs err_count (16 bits) and last_err_group (GROUP_W bits).
  - err_count increments, saturating at 16'hFFFF, on every response with a nonzero code.
  - last_err_group captures that request's group.
  - Both reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sysreg_star_pkg:
  - typedef enum of resp codes (RESP_OK, RESP_NODE_ERR, RESP_UNMAPPED, RESP_TIMEOUT)
  - typedef enum of FSM states (IDLE, ISSUE, WAIT, RESP)
  - default REG_WIDTH, GROUP_W and REGNUM_W constants
- One natural sub-module: sysreg_star_timeout, a loadable saturating counter with an expiry flag.

Test Plan:
- Read group 10, regnum 3, plevel 2; node 10 acks 2 cycles after node_en with rdata 64'hDEAD_BEEF → node_en=11'b100_0000_0000 for exactly 1 cycle, regnum=3, plevel=2; resp_code=0, resp_rdata=64'hDEAD_BEEF.
- Write group 4, wdata 64'h1234; node 4 acks in the ISSUE cycle → resp_valid at N+2, code 0, rdata 0; node_wdata=64'h1234.
- Read group 20 (unmapped) → node_en stays 0, resp_code=2, resp_valid at N+1.
- Read group 1; node never acks, TIMEOUT=15 → resp_code=3 at N+17. Ack injected at N+18 is ignored; the next request completes normally.
- Node 5 acks with node_err=1 while node 6 acks spuriously; resp_ready held low 4 cycles → code 1; response held stable 4 cycles; req_ready=0 throughout.
- rst asserted during WAIT → all outputs return to reset values next cycle; a subsequent ack produces no response. With SYSREG_STAR_ERR_STATUS_EN defined, after 3 error responses err_count=3.

Source files
------------

// File: rtl/sysreg_star_ctrl_pkg.sv
// Shared types and default widths for the sysreg star controller.
// Optional error-status outputs are enabled by SYSREG_STAR_ERR_STATUS_EN.
package sysreg_star_pkg;

  localparam int unsigned DEF_REG_WIDTH = 64;
  localparam int unsigned DEF_GROUP_W   = 5;
  localparam int unsigned DEF_REGNUM_W  = 3;

  typedef enum logic [1:0] {
    RESP_OK       = 2'd0,
    RESP_NODE_ERR = 2'd1,
    RESP_UNMAPPED = 2'd2,
    RESP_TIMEOUT  = 2'd3
  } resp_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/sysreg_star_ctrl_if.sv
// Request/response channels plus node-side star signals of the sysreg controller.
// master = core/node environment side, slave = controller side.
interface sysreg_star_ctrl_if
  import sysreg_star_pkg::*;
#(
  parameter int unsigned REG_WIDTH = DEF_REG_WIDTH,
  parameter int unsigned NR_NODES  = 11,
  parameter int unsigned GROUP_W   = DEF_GROUP_W,
  parameter int unsigned REGNUM_W  = DEF_REGNUM_W
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [GROUP_W-1:0]   req_group;
  logic [REGNUM_W-1:0]  req_regnum;
  logic [1:0]           req_plevel;
  logic [REG_WIDTH-1:0] req_wdata;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [1:0]           resp_code;
  logic [REG_WIDTH-1:0] resp_rdata;

  logic [NR_NODES-1:0]  node_en;
  logic                 node_write;
  logic [REGNUM_W-1:0]  node_regnum;
  logic [1:0]           node_plevel;
  logic [REG_WIDTH-1:0] node_wdata;
  logic [NR_NODES-1:0]  node_ack;
  logic [NR_NODES-1:0]  node_err;
  logic [REG_WIDTH-1:0] node_rdata [NR_NODES];

  modport master (
    output req_valid, req_write, req_group, req_regnum, req_plevel, req_wdata,
    input  req_ready,
    input  resp_valid, resp_code, resp_rdata,
    output resp_ready,
    input  node_en, node_write, node_regnum, node_plevel, node_wdata,
    output node_ack, node_err, node_rdata
  );

  modport slave (
    input  req_valid, req_write, req_group, req_regnum, req_plevel, req_wdata,
    output req_ready,
    output resp_valid, resp_code, resp_rdata,
    input  resp_ready,
    output node_en, node_write, node_regnum, node_plevel, node_wdata,
    input  node_ack, node_err, node_rdata
  );

endinterface

// File: rtl/sysreg_star_ctrl_timeout.sv
// Saturating wait counter: cleared on load, counts while enabled, flags the
// cycle in which the count would reach TIMEOUT.
module sysreg_star_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is reported on the increment that lands on TIMEOUT.
  assign o_expire = i_inc && (r_cnt >= LAST);

endmodule

// File: rtl/sysreg_star_ctrl.sv
// Registered sysreg star controller: one outstanding request, per-node ack,
// unmapped-group and timeout detection. Macro SYSREG_STAR_ERR_STATUS_EN adds error status.
module sysreg_star_ctrl
  import sysreg_star_pkg::*;
#(
  parameter int unsigned REG_WIDTH = DEF_REG_WIDTH,
  parameter int unsigned NR_NODES  = 11,
  parameter int unsigned GROUP_W   = DEF_GROUP_W,
  parameter int unsigned REGNUM_W  = DEF_REGNUM_W,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic clk,
  input  logic rst,
  sysreg_star_ctrl_if.slave bus
`ifdef SYSREG_STAR_ERR_STATUS_EN
  ,
  output logic [15:0]        err_count,
  output logic [GROUP_W-1:0] last_err_group
`endif
);

  localparam int unsigned IDX_W = (NR_NODES > 1) ? $clog2(NR_NODES) : 1;
  localparam logic [NR_NODES-1:0] EN_ONE = NR_NODES'(1);

  state_e               r_state, w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_write;
  logic [NR_NODES-1:0]  r_node_en, w_node_en_next;
  logic                 r_node_write;
  logic [REGNUM_W-1:0]  r_node_regnum;
  logic [1:0]           r_node_plevel;
  logic [REG_WIDTH-1:0] r_node_wdata;
  resp_code_e           r_resp_code, w_resp_code;
  logic [REG_WIDTH-1:0] r_resp_rdata, w_resp_rdata;

  logic                 w_mapped;
  logic                 w_capture;
  logic                 w_resp_load;
  logic                 w_ack;
  logic                 w_err;
  logic [REG_WIDTH-1:0] w_rd;
  logic                 w_cnt_clear;
  logic                 w_cnt_inc;
  logic                 w_expire;

  assign w_mapped    = 32'(bus.req_group) < NR_NODES;
  assign w_ack       = bus.node_ack[r_idx];
  assign w_err       = bus.node_err[r_idx];
  assign w_rd        = bus.node_rdata[r_idx];
  assign w_cnt_clear = (r_state == ISSUE);
  assign w_cnt_inc   = (r_state == WAIT);

  sysreg_star_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cnt_clear),
    .i_inc    (w_cnt_inc),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_node_en_next = '0;
    w_capture      = 1'b0;
    w_resp_load    = 1'b0;
    w_resp_code    = RESP_OK;
    w_resp_rdata   = '0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_mapped) begin
            w_capture      = 1'b1;
            w_node_en_next = EN_ONE << bus.req_group;
            w_state_next   = ISSUE;
          end else begin
            w_resp_load  = 1'b1;
            w_resp_code  = RESP_UNMAPPED;
            w_state_next = RESP;
          end
        end
      end
      // ISSUE also accepts the ack so combinational nodes finish in one cycle;
      // an ack coinciding with expiry takes priority over the timeout.
      ISSUE, WAIT: begin
        if (w_ack) begin
          w_resp_load  = 1'b1;
          w_resp_code  = w_err ? RESP_NODE_ERR : RESP_OK;
          w_resp_rdata = (!w_err && !r_write) ? w_rd : '0;
          w_state_next = RESP;
        end else if (r_state == ISSUE) begin
          w_state_next = WAIT;
        end else if (w_expire) begin
          w_resp_load  = 1'b1;
          w_resp_code  = RESP_TIMEOUT;
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= '0;
      r_write       <= 1'b0;
      r_node_en     <= '0;
      r_node_write  <= 1'b0;
      r_node_regnum <= '0;
      r_node_plevel <= '0;
      r_node_wdata  <= '0;
      r_resp_code   <= RESP_OK;
      r_resp_rdata  <= '0;
    end else begin
      r_node_en <= w_node_en_next;
      if (w_capture) begin
        r_idx         <= IDX_W'(bus.req_group);
        r_write       <= bus.req_write;
        r_node_write  <= bus.req_write;
        r_node_regnum <= bus.req_regnum;
        r_node_plevel <= bus.req_plevel;
        r_node_wdata  <= bus.req_wdata;
      end
      if (w_resp_load) begin
        r_resp_code  <= w_resp_code;
        r_resp_rdata <= w_resp_rdata;
      end
    end
  end

`ifdef SYSREG_STAR_ERR_STATUS_EN
  logic [GROUP_W-1:0] r_group;
  logic [15:0]        r_err_count;
  logic [GROUP_W-1:0] r_last_err_group;
  logic [GROUP_W-1:0] w_err_group;

  // Unmapped requests respond straight from IDLE, before r_group is loaded.
  assign w_err_group = (r_state == IDLE) ? bus.req_group : r_group;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_group          <= '0;
      r_err_count      <= '0;
      r_last_err_group <= '0;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_group <= bus.req_group;
      end
      if (w_resp_load && (w_resp_code != RESP_OK)) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + 16'd1;
        end
        r_last_err_group <= w_err_group;
      end
    end
  end

  assign err_count      = r_err_count;
  assign last_err_group = r_last_err_group;
`endif

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.resp_valid  = (r_state == RESP);
  assign bus.resp_code   = r_resp_code;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.node_en     = r_node_en;
  assign bus.node_write  = r_node_write;
  assign bus.node_regnum = r_node_regnum;
  assign bus.node_plevel = r_node_plevel;
  assign bus.node_wdata  = r_node_wdata;

endmodule
